// File: rtl/dmem_pkg.sv
// Shared types for the sub-word data memory: size codes, FSM states,
// latched request bundle and address-alignment helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        lu;
        logic [31:0] wdata;
    } req_t;

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic m;
        unique case (1'b1)
            size == SZ_BYTE: m = 1'b0;
            size == SZ_HALF: m = off[0];
            default:         m = (off != 2'b00);
        endcase
        return m;
    endfunction

    // Size code 11 behaves as a word access.
    function automatic logic [1:0] align_off(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [1:0] o;
        unique case (1'b1)
            size == SZ_BYTE: o = off;
            size == SZ_HALF: o = {off[1], 1'b0};
            default:         o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Byte-lane steering: byte enables, store-data replication and
// load lane extraction with sign/zero extension.
module dmem_lane_steer
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rword_i[{off_i, 3'b000} +: 8];
    assign lane_h = off_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
        unique case (1'b1)
            size_i == SZ_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & lane_b[7]}}, lane_b};
            end
            size_i == SZ_HALF: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_subword.sv
// Sub-word data memory with WAIT_CYCLES wait states and a ready pulse.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module data_memory_subword
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              misalign
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LOW_W = IDX_W + 2;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e           state_q;
    logic [3:0]       cnt_q;
    req_t             req_q;
    logic [LOW_W-1:0] addr_q;
    logic [31:0]      rdata_q;
    logic             ready_q;
    logic             busy_q;
    logic             mis_q;

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

    req_t             req_live;
    req_t             acc;
    logic [LOW_W-1:0] acc_addr;
    logic             go_now;
    logic             enter_done;
    logic             mis;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      st_data;
    logic [31:0]      ld_data;

    generate
        if (ADDR_W > LOW_W) begin : g_hi_addr
            logic unused_addr;
            assign unused_addr = ^addr[ADDR_W-1:LOW_W];
        end
    endgenerate

    assign req_live = '{we: we, size: size, lu: load_unsigned, wdata: wdata};

    // Zero-wait accesses complete on the accepting edge, so they must use
    // the live inputs rather than the not-yet-latched copy.
    assign go_now     = (state_q == IDLE) && req && (WAIT_CYCLES == 0);
    assign enter_done = go_now || ((state_q == WAIT) && (cnt_q == 4'd0));
    assign acc        = go_now ? req_live : req_q;
    assign acc_addr   = go_now ? addr[LOW_W-1:0] : addr_q;
    assign idx        = acc_addr[LOW_W-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = is_misaligned(acc.size, acc_addr[1:0]);
    assign off = acc_addr[1:0];
`else
    assign mis = 1'b0;
    assign off = align_off(acc.size, acc_addr[1:0]);
`endif

    dmem_lane_steer u_steer (
        .size_i     (acc.size),
        .off_i      (off),
        .unsigned_i (acc.lu),
        .wdata_i    (acc.wdata),
        .rword_i    (mem_q[idx]),
        .be_o       (be),
        .wdata_o    (st_data),
        .rdata_o    (ld_data)
    );

    // Storage is never reset; reset_n gating keeps aborted stores out.
    always_ff @(posedge clock) begin
        if (reset_n && enter_done && acc.we && !mis) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            mis_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        req_q   <= req_live;
                        addr_q  <= addr[LOW_W-1:0];
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (enter_done) begin
                state_q <= DONE;
                ready_q <= 1'b1;
                mis_q   <= mis;
                rdata_q <= (acc.we || mis) ? 32'd0 : ld_data;
            end
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign misalign = mis_q;

endmodule

// File: tb/tb_data_memory_subword.sv
// Directed bench: one-wait-state instance plus a zero-wait instance
// for back-to-back streaming and address aliasing.
module tb_data_memory_subword;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req1, we1, lu1, ready1, busy1, mis1;
    logic [1:0]  size1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        req0, we0, lu0, ready0, busy0, mis0;
    logic [1:0]  size0;
    logic [31:0] addr0, wdata0, rdata0;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    data_memory_subword #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .req(req1), .we(we1),
        .size(size1), .load_unsigned(lu1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ready(ready1), .busy(busy1), .misalign(mis1)
    );

    data_memory_subword #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
        .clock(clock), .reset_n(reset_n), .req(req0), .we(we0),
        .size(size0), .load_unsigned(lu0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .misalign(mis0)
    );

    task automatic drive(input bit w0, input logic r, input logic w,
                         input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        if (w0) begin
            req0 = r; we0 = w; size0 = s; lu0 = u; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; size1 = s; lu1 = u; addr1 = a; wdata1 = d;
        end
    endtask

    // One access; inputs are scrambled after acceptance.
    task automatic xfer(input bit w0, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic m, output int lat, output logic bsy);
        @(negedge clock);
        drive(w0, 1'b1, w, s, u, a, d);
        @(posedge clock);
        lat = 99; rd = 'x; m = 'x; bsy = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (n == 1) begin
                drive(w0, 1'b0, ~w, ~s, ~u, ~a, ~d);
                bsy = w0 ? busy0 : busy1;
            end
            if ((w0 ? ready0 : ready1) === 1'b1) begin
                lat = n;
                rd  = w0 ? rdata0 : rdata1;
                m   = w0 ? mis0 : mis1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(1'b0, 0, 0, 2'b00, 0, 0, 0);
        drive(1'b1, 0, 0, 2'b00, 0, 0, 0);
        #2;
        vectors++; if (ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready1); end
        vectors++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy1); end
        vectors++; if (mis1 !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", mis1); end
        vectors++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata1); end
        vectors++; if ({ready0, busy0} !== 2'b00) begin errors++; $display("FAIL rst_dut0: got %b want 00", {ready0, busy0}); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic m, b; int lat;
        xfer(1'b0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, m, lat, b);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL sw_lat: got %0d want 2", lat); end
        vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h want 0", rd); end
        vectors++; if (b !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b want 1", b); end
        xfer(1'b0, 0, 2'b10, 0, 32'h10, 32'h0, rd, m, lat, b);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL lw_lat: got %0d want 2", lat); end
        vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        vectors++; if (m !== 1'b0) begin errors++; $display("FAIL lw_mis: got %b want 0", m); end
        @(negedge clock);
        vectors++; if ({ready1, busy1} !== 2'b00) begin errors++; $display("FAIL lw_after: got %b want 00", {ready1, busy1}); end
        vectors++; if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hold: got %h want deadbeef", rdata1); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic m, b; int lat;
        xfer(1'b0, 1, 2'b00, 0, 32'h13, 32'h7F, rd, m, lat, b);
        xfer(1'b0, 0, 2'b10, 0, 32'h10, 32'h0, rd, m, lat, b);
        vectors++; if (rd !== 32'h7FADBEEF) begin errors++; $display("FAIL sb_lw: got %h want 7fadbeef", rd); end
        xfer(1'b0, 0, 2'b00, 0, 32'h12, 32'h0, rd, m, lat, b);
        vectors++; if (rd !== 32'hFFFFFFAD) begin errors++; $display("FAIL lb: got %h want ffffffad", rd); end
        xfer(1'b0, 0, 2'b00, 1, 32'h12, 32'h0, rd, m, lat, b);
        vectors++; if (rd !== 32'h000000AD) begin errors++; $display("FAIL lbu: got %h want 000000ad", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic m, b; int lat;
        xfer(1'b0, 1, 2'b01, 0, 32'h22, 32'h8001, rd, m, lat, b);
        xfer(1'b0, 0, 2'b01, 0, 32'h22, 32'h0, rd, m, lat, b);
        vectors++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh: got %h want ffff8001", rd); end
        xfer(1'b0, 0, 2'b01, 1, 32'h22, 32'h0, rd, m, lat, b);
        vectors++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu: got %h want 00008001", rd); end
        xfer(1'b0, 0, 2'b10, 0, 32'h20, 32'h0, rd, m, lat, b);
        vectors++; if (rd !== 32'h80010000) begin errors++; $display("FAIL sh_lw: got %h want 80010000", rd); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic m, b; int lat;
        xfer(1'b0, 0, 2'b10, 0, 32'h11, 32'h0, rd, m, lat, b);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL mis_lat: got %0d want 2", lat); end
`ifdef DMEM_MISALIGN_TRAP_EN
        vectors++; if (m !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", m); end
        vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h want 0", rd); end
`else
        vectors++; if (m !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b want 0", m); end
        vectors++; if (rd !== 32'h7FADBEEF) begin errors++; $display("FAIL mis_rdata: got %h want 7fadbeef", rd); end
`endif
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic m, b; int lat; logic seen;
        @(negedge clock);
        drive(1'b0, 1, 1, 2'b10, 0, 32'h40, 32'h12345678);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        req1 = 1'b0;
        #1;
        vectors++; if ({ready1, busy1} !== 2'b00) begin errors++; $display("FAIL abort_rst: got %b want 00", {ready1, busy1}); end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (ready1 !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", seen); end
        xfer(1'b0, 0, 2'b10, 0, 32'h40, 32'h0, rd, m, lat, b);
        vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_mem: got %h want 0", rd); end
    endtask

    task automatic test_alias;
        logic [31:0] rd; logic m, b; int lat;
        xfer(1'b1, 1, 2'b10, 0, 32'h400, 32'hA5A55A5A, rd, m, lat, b);
        vectors++; if (lat !== 1) begin errors++; $display("FAIL w0_lat: got %0d want 1", lat); end
        xfer(1'b1, 0, 2'b10, 0, 32'h0, 32'h0, rd, m, lat, b);
        vectors++; if (rd !== 32'hA5A55A5A) begin errors++; $display("FAIL alias: got %h want a5a55a5a", rd); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] pat; logic bad;
        bad = 1'b0;
        @(negedge clock);
        drive(1'b1, 1, 0, 2'b10, 0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            pat[i] = ready0;
            if (ready0 === 1'b1 && rdata0 !== 32'hA5A55A5A) bad = 1'b1;
        end
        req0 = 1'b0;
        vectors++; if (pat !== 10'b0101010101) begin errors++; $display("FAIL b2b_ready: got %b want 0101010101", pat); end
        vectors++; if (bad !== 1'b0) begin errors++; $display("FAIL b2b_rdata: got %b want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_reset_abort();
        test_alias();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
